// File: rtl/line_mem_pkg.sv
// Shared types and helpers for the cache-line memory responder: FSM state
// encoding, line geometry and address-to-line-index helpers.
package line_mem_pkg;

  localparam int LINE_BYTES = 32;
  localparam int OFFSET_W   = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_e;

  // Line index for a byte address; upper bits wrap modulo depth.
  function automatic int unsigned line_index(input logic [63:0] addr,
                                             input int unsigned depth);
    logic [63:0] line;
    line = addr >> OFFSET_W;
    return 32'(line % 64'(depth));
  endfunction

  function automatic logic line_out_of_range(input logic [63:0] addr,
                                             input int unsigned depth);
    return (addr >> OFFSET_W) >= 64'(depth);
  endfunction

endpackage

// File: rtl/line_mem_responder_if.sv
// Request/response bundle between the dcache line port and the memory
// responder; err_o exists only when LINE_MEM_RESP_ERR_EN is defined.
interface line_mem_responder_if #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 32
);
  logic              enable_i;
  logic              write_i;
  logic [ADDR_W-1:0] addr_i;
  logic [DATA_W-1:0] data_i;
  logic              ack_o;
  logic [DATA_W-1:0] data_o;
`ifdef LINE_MEM_RESP_ERR_EN
  logic              err_o;
`endif

  modport master (
    output enable_i, write_i, addr_i, data_i,
`ifdef LINE_MEM_RESP_ERR_EN
    input  err_o,
`endif
    input  ack_o, data_o
  );

  modport slave (
    input  enable_i, write_i, addr_i, data_i,
`ifdef LINE_MEM_RESP_ERR_EN
    output err_o,
`endif
    output ack_o, data_o
  );
endinterface

// File: rtl/line_mem_array.sv
// DEPTH x DATA_W line storage with one synchronous write port and one
// synchronous read port whose output register resets to zero.
module line_mem_array #(
  parameter int DATA_W = 256,
  parameter int DEPTH  = 512,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              re_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] memory [0:DEPTH-1];
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  // NOTE: the storage array has no reset; clearing it would turn the RAM into
  // DEPTH*DATA_W flops, and benches preload it by hierarchical reference.
  always_ff @(posedge clk_i) begin
    if (we_i) memory[wr_idx_i] <= wr_data_i;
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (re_i) rd_data_d = memory[rd_idx_i];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rd_data_q <= '0;
    else       rd_data_q <= rd_data_d;
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/line_mem_responder.sv
// Fixed-latency cache-line memory responder: one outstanding request, IDLE ->
// WAIT -> ACK. Optional out-of-range reporting via LINE_MEM_RESP_ERR_EN.
module line_mem_responder
  import line_mem_pkg::*;
#(
  parameter int DATA_W  = 256,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 512,
  parameter int LATENCY = 10
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  line_mem_responder_if.slave  bus
);

  localparam int         IDX_W    = $clog2(DEPTH);
  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                write_q, write_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                oor_q, oor_d;
  logic                mem_we, mem_re;
  logic [DATA_W-1:0]   rd_data;

`ifdef LINE_MEM_RESP_ERR_EN
  logic zero_q, zero_d;
`endif

  // NOTE: every always_comb output gets a default first so no path through
  // the case statement can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    oor_d   = oor_q;
    mem_we  = 1'b0;
    mem_re  = 1'b0;
`ifdef LINE_MEM_RESP_ERR_EN
    zero_d  = zero_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.enable_i) begin
          state_d = S_WAIT;
          cnt_d   = CNT_INIT;
          write_d = bus.write_i;
          idx_d   = IDX_W'(line_index(64'(bus.addr_i), DEPTH));
          wdata_d = bus.data_i;
`ifdef LINE_MEM_RESP_ERR_EN
          oor_d   = line_out_of_range(64'(bus.addr_i), DEPTH);
`else
          oor_d   = 1'b0;
`endif
        end
      end
      S_WAIT: begin
        if (cnt_q == 8'd0) begin
          // The storage access happens on the edge that enters ACK.
          state_d = S_ACK;
          mem_we  = write_q && !oor_q;
          mem_re  = !write_q && !oor_q;
`ifdef LINE_MEM_RESP_ERR_EN
          if (!write_q) zero_d = oor_q;
`endif
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      oor_q   <= oor_d;
    end
  end

`ifdef LINE_MEM_RESP_ERR_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) zero_q <= 1'b0;
    else       zero_q <= zero_d;
  end
`endif

  line_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .we_i      (mem_we),
    .wr_idx_i  (idx_q),
    .wr_data_i (wdata_q),
    .re_i      (mem_re),
    .rd_idx_i  (idx_q),
    .rd_data_o (rd_data)
  );

  assign bus.ack_o = (state_q == S_ACK);

`ifdef LINE_MEM_RESP_ERR_EN
  assign bus.data_o = zero_q ? '0 : rd_data;
  assign bus.err_o  = (state_q == S_ACK) && oor_q;
`else
  assign bus.data_o = rd_data;
`endif

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed bench for line_mem_responder: latency, read/write, back-to-back,
// reset abort, LATENCY=1, address wrap or out-of-range error.
module tb_line_mem_responder;
  import line_mem_pkg::*;

  localparam int DATA_W = 256;
  localparam int ADDR_W = 32;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   cyc   = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  line_mem_responder_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus0 ();
  line_mem_responder_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus1 ();

  line_mem_responder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(512), .LATENCY(10))
    dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus0));

  line_mem_responder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(512), .LATENCY(1))
    dut1 (.clk_i(clk_i), .rst_i(rst_i), .bus(bus1));

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc++;

  localparam logic [255:0] PAT_BEEF = {8{32'hDEADBEEF}};

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Waits for ack on bus0, counting edges; returns -1 on timeout.
  task automatic wait_ack(input string tag, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!bus0.ack_o && n < 64);
    if (!bus0.ack_o) begin
      check({tag, "_timeout"}, 256'(bus0.ack_o), 256'(1));
      n = -1;
    end
  endtask

  // Issues one request on bus0 and scrambles the inputs right after the
  // accepting edge, so the result must come from the latched request.
  task automatic do_req(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [255:0] wdata, output int lat);
    bus0.enable_i = 1'b1;
    bus0.write_i  = wr;
    bus0.addr_i   = addr;
    bus0.data_i   = wdata;
    step();
    bus0.write_i  = ~wr;
    bus0.addr_i   = addr ^ 32'h20;
    bus0.data_i   = ~wdata;
    wait_ack(tag, lat);
    lat++;
    bus0.enable_i = 1'b0;
  endtask

  initial begin
    int lat;
    int t1;
    int t2;
    int n;
    bit seen_ack;

    bus0.enable_i = 1'b0; bus0.write_i = 1'b0; bus0.addr_i = '0; bus0.data_i = '0;
    bus1.enable_i = 1'b0; bus1.write_i = 1'b0; bus1.addr_i = '0; bus1.data_i = '0;

    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_ack",    256'(bus0.ack_o), 256'(0));
    check("rst_data",   bus0.data_o, 256'(0));
    check("rst_state",  256'(dut.state_q), 256'(S_IDLE));
    check("rst_cnt",    256'(dut.cnt_q), 256'(0));
    check("rst_ack_l1", 256'(bus1.ack_o), 256'(0));
`ifdef LINE_MEM_RESP_ERR_EN
    check("rst_err",    256'(bus0.err_o), 256'(0));
`endif
    rst_i = 1'b0;

    dut.u_array.memory[0]  = 256'h5;
    dut.u_array.memory[2]  = 256'hA;
    dut.u_array.memory[3]  = 256'hB;
    dut.u_array.memory[32] = 256'h77;
    dut1.u_array.memory[2] = 256'h42;
    step();

    // Read hit on preloaded line 0 (do_req returns lat+1, undo that)
    do_req("rd0", 1'b0, 32'h0, '0, lat);
    check("rd0_latency", 256'(lat - 1), 256'(10));
    check("rd0_data",    bus0.data_o, 256'h5);
`ifdef LINE_MEM_RESP_ERR_EN
    check("rd0_err",     256'(bus0.err_o), 256'(0));
`endif
    step();
    check("rd0_ack_width", 256'(bus0.ack_o), 256'(0));
    check("rd0_data_hold", bus0.data_o, 256'h5);

    // Write line 1, then read it back
    do_req("wr1", 1'b1, 32'h20, PAT_BEEF, lat);
    check("wr1_latency",   256'(lat - 1), 256'(10));
    check("wr1_mem",       dut.u_array.memory[1], PAT_BEEF);
    check("wr1_data_kept", bus0.data_o, 256'h5);
    step();
    do_req("rd1", 1'b0, 32'h20, '0, lat);
    check("rd1_data", bus0.data_o, PAT_BEEF);
    step();

    // Back-to-back with address change mid-WAIT, enable held high
    bus0.enable_i = 1'b1; bus0.write_i = 1'b0; bus0.addr_i = 32'h40;
    step();
    repeat (3) step();
    bus0.addr_i = 32'h60;
    wait_ack("b2b_a", n);
    t1 = cyc;
    check("b2b_a_data", bus0.data_o, 256'hA);
    step();
    check("b2b_gap_idle", 256'(dut.state_q), 256'(S_IDLE));
    step();
    check("b2b_accept",   256'(dut.state_q), 256'(S_WAIT));
    wait_ack("b2b_b", n);
    t2 = cyc;
    bus0.enable_i = 1'b0;
    // 11 non-ack cycles between the two pulses
    check("b2b_spacing", 256'(t2 - t1), 256'(12));
    check("b2b_b_data",  bus0.data_o, 256'hB);
    step();

    // Reset in cycle 5 of WAIT aborts a write to line 32
    bus0.enable_i = 1'b1; bus0.write_i = 1'b1; bus0.addr_i = 32'h400;
    bus0.data_i = 256'hFF;
    step();
    repeat (4) step();
    rst_i = 1'b1;
    #1;
    check("rst_mid_state", 256'(dut.state_q), 256'(S_IDLE));
    check("rst_mid_data",  bus0.data_o, 256'(0));
    #1;
    rst_i = 1'b0;
    bus0.enable_i = 1'b0;
    seen_ack = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      seen_ack |= bus0.ack_o;
    end
    check("rst_mid_no_ack", 256'(seen_ack), 256'(0));
    check("rst_mid_mem32",  dut.u_array.memory[32], 256'h77);
    do_req("rst_rd0", 1'b0, 32'h0, '0, lat);
    check("rst_rd0_latency", 256'(lat - 1), 256'(10));
    check("rst_rd0_data",    bus0.data_o, 256'h5);
    step();

    // LATENCY=1 instance
    bus1.enable_i = 1'b1; bus1.write_i = 1'b0; bus1.addr_i = 32'h40;
    step();
    bus1.addr_i = 32'h0;
    n = 0;
    do begin
      step();
      n++;
    end while (!bus1.ack_o && n < 8);
    bus1.enable_i = 1'b0;
    check("l1_latency", 256'(n), 256'(1));
    check("l1_data",    bus1.data_o, 256'h42);
    step();
    check("l1_ack_width", 256'(bus1.ack_o), 256'(0));

`ifdef LINE_MEM_RESP_ERR_EN
    // Out-of-range read and write
    do_req("oor_rd", 1'b0, 32'h4000, '0, lat);
    check("oor_rd_ack",  256'(bus0.ack_o), 256'(1));
    check("oor_rd_err",  256'(bus0.err_o), 256'(1));
    check("oor_rd_data", bus0.data_o, 256'(0));
    step();
    check("oor_err_width", 256'(bus0.err_o), 256'(0));
    do_req("oor_wr", 1'b1, 32'h4000, 256'hBAD, lat);
    check("oor_wr_err",  256'(bus0.err_o), 256'(1));
    check("oor_wr_mem0", dut.u_array.memory[0], 256'h5);
    step();
    do_req("oor_after_rd", 1'b0, 32'h20, '0, lat);
    check("oor_after_data", bus0.data_o, PAT_BEEF);
    check("oor_after_err",  256'(bus0.err_o), 256'(0));
    step();
`else
    // Address wrap modulo 512 lines
    do_req("wrap_rd", 1'b0, 32'h4000, '0, lat);
    check("wrap_rd_data", bus0.data_o, 256'h5);
    step();
    do_req("wrap_wr", 1'b1, 32'h4020, 256'hC0FFEE, lat);
    check("wrap_wr_mem1", dut.u_array.memory[1], 256'hC0FFEE);
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
